md_unit: RTL and testbench

// - Multiply/divide unit in the E stage: consumes the rs/rt operands read from GRF
//   (after forwarding), owns the HI/LO registers, and returns HI/LO to the GRF write path via mfhi/mflo.
// - Models multi-cycle latency with a busy counter.
// - Hazard logic uses `busy` to stall MD-class instructions held in the D stage.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_unit_if.sv | 22 ++
 rtl/md_arith.sv | 39 +++
 rtl/md_unit.sv | 79 +++++++
 tb/tb_md_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and counter sizing.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MFHI    = 4'd7,
        MFLO    = 4'd8
    } mdOp_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic int cntWidth(input int multCycles, input int divCycles);
        return $clog2(((multCycles > divCycles) ? multCycles : divCycles) + 1);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface md_unit_if;
    import md_pkg::*;

    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] md_rdata;

    modport master (
        output md_start, md_op, rs_val, rt_val,
        input  busy, md_rdata
    );

    modport slave (
        input  md_start, md_op, rs_val, rt_val,
        output busy, md_rdata
    );

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder, signed or unsigned.
module md_arith (
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        isSigned,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divZero
);

    logic               negA;
    logic               negB;
    logic signed [63:0] extA;
    logic signed [63:0] extB;
    logic [31:0]        magA;
    logic [31:0]        magB;
    logic [31:0]        divisor;
    logic [31:0]        magQ;
    logic [31:0]        magR;

    // Division runs on magnitudes so 0x80000000 / -1 cannot overflow the host divide.
    always_comb begin
        negA      = isSigned & opA[31];
        negB      = isSigned & opB[31];
        extA      = $signed({{32{negA}}, opA});
        extB      = $signed({{32{negB}}, opB});
        product   = 64'(extA * extB);
        magA      = negA ? (32'd0 - opA) : opA;
        magB      = negB ? (32'd0 - opB) : opB;
        divZero   = (opB == 32'd0);
        divisor   = divZero ? 32'd1 : magB;
        magQ      = magA / divisor;
        magR      = magA % divisor;
        quotient  = (negA ^ negB) ? (32'd0 - magQ) : magQ;
        remainder = negA ? (32'd0 - magR) : magR;
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, computes at accept, commits after a fixed busy latency.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   mdIf
);

    localparam int CNT_W = cntWidth(MULT_CYCLES, DIV_CYCLES);

    logic [31:0]      hiReg;
    logic [31:0]      loReg;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic             commitEn;
    logic [CNT_W-1:0] count;

    logic             isSigned;
    logic [63:0]      product;
    logic [31:0]      quotient;
    logic [31:0]      remainder;
    logic             divZero;

    assign isSigned = (mdIf.md_op == MULT) || (mdIf.md_op == DIV);

    md_arith uArith (
        .opA       (mdIf.rs_val),
        .opB       (mdIf.rt_val),
        .isSigned  (isSigned),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder),
        .divZero   (divZero)
    );

    // Any start while count != 0 (including the commit edge) is dropped here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg    <= '0;
            loReg    <= '0;
            pendHi   <= '0;
            pendLo   <= '0;
            commitEn <= 1'b0;
            count    <= '0;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1) && commitEn) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end
        end else if (mdIf.md_start) begin
            case (mdIf.md_op)
                MULT, MULTU: begin
                    pendHi   <= product[63:32];
                    pendLo   <= product[31:0];
                    commitEn <= 1'b1;
                    count    <= CNT_W'(MULT_CYCLES);
                end
                DIV, DIVU: begin
                    pendHi   <= remainder;
                    pendLo   <= quotient;
                    commitEn <= !divZero;
                    count    <= CNT_W'(DIV_CYCLES);
                end
                MTHI:    hiReg <= mdIf.rs_val;
                MTLO:    loReg <= mdIf.rs_val;
                default: ;
            endcase
        end
    end

    assign mdIf.busy     = (count != '0);
    assign mdIf.md_rdata = (mdIf.md_op == MFHI) ? hiReg : loReg;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO queued at issue, checked when busy drops.
module tb_md_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset;

    md_unit_if mdIf ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdIf  (mdIf)
    );

    always #5 clk = ~clk;

    int          assertCnt = 0;
    int          failCnt   = 0;
    logic [31:0] expHiQ[$];
    logic [31:0] expLoQ[$];
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    logic [31:0] oldLo;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model evaluated in 64-bit host arithmetic.
    function automatic void pushExpect(input mdOp_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        case (op)
            MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            DIV, DIVU: begin
                if (b != 32'd0) begin
                    sa = (op == DIV) ? longint'($signed(a)) : longint'({32'b0, a});
                    sb = (op == DIV) ? longint'($signed(b)) : longint'({32'b0, b});
                    q = sa / sb;
                    r = sa % sb;
                    modelLo = q[31:0];
                    modelHi = r[31:0];
                end
            end
            MTHI: modelHi = a;
            MTLO: modelLo = a;
            default: ;
        endcase
        expHiQ.push_back(modelHi);
        expLoQ.push_back(modelLo);
    endfunction

    task automatic issue(input mdOp_t op, input logic [31:0] a, input logic [31:0] b);
        mdIf.md_start = 1'b1;
        mdIf.md_op    = op;
        mdIf.rs_val   = a;
        mdIf.rt_val   = b;
        @(negedge clk);
        mdIf.md_start = 1'b0;
        mdIf.md_op    = MD_NONE;
    endtask

    task automatic waitIdle(input string tag, input int expN);
        int n = 0;
        while (mdIf.busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        checkVal(tag, 32'(n), 32'(expN));
    endtask

    task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
        mdIf.md_op = MFHI;
        #1 hi = mdIf.md_rdata;
        mdIf.md_op = MFLO;
        #1 lo = mdIf.md_rdata;
        mdIf.md_op = MD_NONE;
    endtask

    task automatic checkResult(input string tag);
        logic [31:0] h;
        logic [31:0] l;
        readHiLo(h, l);
        if (expHiQ.size() == 0) begin
            assertCnt++;
            failCnt++;
            $display("FAIL %s: got empty scoreboard expected queued result", tag);
        end else begin
            checkVal({tag, "_hi"}, h, expHiQ.pop_front());
            checkVal({tag, "_lo"}, l, expLoQ.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        mdIf.md_start = 1'b0;
        mdIf.md_op    = MD_NONE;
        mdIf.rs_val   = '0;
        mdIf.rt_val   = '0;
        repeat (2) @(negedge clk);
        checkVal("reset_busy", {31'b0, mdIf.busy}, 32'd0);
        checkResult_reset: begin
            logic [31:0] h;
            logic [31:0] l;
            readHiLo(h, l);
            checkVal("reset_hi", h, 32'h0);
            checkVal("reset_lo", l, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(MULT, 32'hFFFF_FFFF, 32'd2);
        pushExpect(MULT, 32'hFFFF_FFFF, 32'd2);
        waitIdle("mult_busy", 5);
        checkResult("mult");

        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        pushExpect(MULTU, 32'hFFFF_FFFF, 32'd2);
        waitIdle("multu_busy", 5);
        checkResult("multu");

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        pushExpect(DIV, 32'hFFFF_FFF9, 32'd2);
        waitIdle("div_busy", 10);
        checkResult("div");

        issue(DIVU, 32'd7, 32'd2);
        pushExpect(DIVU, 32'd7, 32'd2);
        waitIdle("divu_busy", 10);
        checkResult("divu");

        issue(MTHI, 32'h1234, 32'd0);
        pushExpect(MTHI, 32'h1234, 32'd0);
        checkVal("mthi_busy", {31'b0, mdIf.busy}, 32'd0);
        checkResult("mthi");
        @(negedge clk);
        issue(MTLO, 32'h5678, 32'd0);
        pushExpect(MTLO, 32'h5678, 32'd0);
        checkResult("mtlo");
        @(negedge clk);
        issue(DIV, 32'h99, 32'd0);
        pushExpect(DIV, 32'h99, 32'd0);
        waitIdle("divzero_busy", 10);
        checkResult("divzero");

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        pushExpect(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle("divovf_busy", 10);
        checkResult("divovf");

        // MTLO and MFLO while a multiply is in flight.
        oldLo = modelLo;
        issue(MULT, 32'd3, 32'd7);
        pushExpect(MULT, 32'd3, 32'd7);
        issue(MTLO, 32'hAA, 32'd0);
        mdIf.md_op = MFLO;
        #1 checkVal("mflo_busy", mdIf.md_rdata, oldLo);
        mdIf.md_op = MD_NONE;
        waitIdle("mult_mtlo_busy", 4);
        checkResult("mult_mtlo");

        // Start held across the commit edge: dropped there, taken on the next edge.
        issue(MULT, 32'd5, 32'd6);
        pushExpect(MULT, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        mdIf.md_start = 1'b1;
        mdIf.md_op    = MULT;
        mdIf.rs_val   = 32'h10;
        mdIf.rt_val   = 32'h20;
        @(negedge clk);
        checkVal("commit_edge_busy", {31'b0, mdIf.busy}, 32'd0);
        checkResult("mult_first");
        mdIf.md_op = MULT;
        @(negedge clk);
        mdIf.md_start = 1'b0;
        mdIf.md_op    = MD_NONE;
        pushExpect(MULT, 32'h10, 32'h20);
        waitIdle("b2b_busy", 5);
        checkResult("mult_b2b");

        issue(MTHI, 32'h11, 32'd0);
        pushExpect(MTHI, 32'h11, 32'd0);
        mdIf.md_op = MFHI;
        #1 checkVal("mthi_mfhi", mdIf.md_rdata, 32'h11);
        mdIf.md_op = MD_NONE;
        checkResult("mthi_b2b");
        @(negedge clk);

        // Asynchronous reset with the divide counter at 6.
        issue(DIV, 32'd100, 32'd3);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 checkVal("async_reset_busy", {31'b0, mdIf.busy}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        modelHi = '0;
        modelLo = '0;
        expHiQ.push_back(modelHi);
        expLoQ.push_back(modelLo);
        checkResult("after_reset");
        @(negedge clk);
        checkVal("after_reset_busy", {31'b0, mdIf.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
